// File: rtl/arb_mux_pkg.sv
// Shared helpers for the N:1 stream multiplexer: index widths, wrapped
// pointer increment and one-hot to index conversion.
package arb_mux_pkg;

   // Upper bound on channel count supported by onehot_to_idx.
   localparam int MAX_N = 256;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Wrapped increment; correct for any n, not just powers of two.
   function automatic int rr_next(input int ptr, input int n);
      return (ptr >= n - 1) ? 0 : ptr + 1;
   endfunction

   function automatic int onehot_to_idx(input logic [MAX_N-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_N; i++) begin
         if (oh[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/arb_mux_n1_rr_arbiter.sv
// Rotating-priority arbiter: scans ptr, ptr+1, ..., wrapping at N-1, and
// moves the pointer past the winner whenever en is high and a grant is made.
module rr_arbiter_n
   import arb_mux_pkg::*;
#(
   parameter int N = 8,
   localparam int SEL_W = sel_width(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] grant_idx
);

   logic [SEL_W-1:0] ptr;
   logic [MAX_N-1:0] grant_pad;
   logic             found;
   int               j;

   always_comb begin
      grant = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            grant[j] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   always_comb begin
      grant_pad         = '0;
      grant_pad[N-1:0]  = grant;
      grant_idx         = SEL_W'(onehot_to_idx(grant_pad));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (en && (|grant)) begin
         ptr <= SEL_W'(rr_next(int'(grant_idx), N));
      end
   end

endmodule

// File: rtl/arb_mux_n1.sv
// Registered N:1 stream multiplexer, fixed-select or round-robin, with a
// single output register that can be refilled in the same cycle it drains.
module arb_mux_n1
   import arb_mux_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter int N         = 8,
   localparam int SEL_W    = sel_width(N)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N*BIT_WIDTH-1:0] recv_msg,
   input  logic [N-1:0]           recv_val,
   output logic [N-1:0]           recv_rdy,
   input  logic                   rr_en,
   input  logic [SEL_W-1:0]       sel,
   output logic [BIT_WIDTH-1:0]   send_msg,
   output logic                   send_val,
   input  logic                   send_rdy,
   output logic [SEL_W-1:0]       send_chan
);

   // Handshake: a word moves on any port in the cycle where val and rdy are
   // both high at the rising edge; val never waits on rdy, and a source
   // holding val must keep its payload stable until the transfer happens.

   logic                 full;
   logic                 can_accept;
   logic [N-1:0]         fix_grant;
   logic [N-1:0]         rr_grant;
   logic [SEL_W-1:0]     rr_idx;
   logic [N-1:0]         grant;
   logic [SEL_W-1:0]     g_idx;
   logic [BIT_WIDTH-1:0] in_msg;
   logic                 xfer_in;
   logic                 xfer_out;

   assign can_accept = !full || send_rdy;

   rr_arbiter_n #(
      .N(N)
   ) u_rr (
      .clk       (clk),
      .reset     (reset),
      .en        (rr_en && can_accept),
      .req       (recv_val),
      .grant     (rr_grant),
      .grant_idx (rr_idx)
   );

   // Out-of-range sel values match no channel and therefore grant nothing.
   always_comb begin
      fix_grant = '0;
      for (int i = 0; i < N; i++) begin
         fix_grant[i] = recv_val[i] && (int'(sel) == i);
      end
   end

   always_comb begin
      grant = rr_en ? rr_grant : fix_grant;
      g_idx = rr_en ? rr_idx : sel;
   end

   always_comb begin
      recv_rdy = '0;
      if (!reset) recv_rdy = grant & {N{can_accept}};
   end

   always_comb begin
      in_msg = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) in_msg = in_msg | recv_msg[i*BIT_WIDTH +: BIT_WIDTH];
      end
   end

   assign xfer_in  = |(recv_val & recv_rdy);
   assign xfer_out = full && send_rdy;

   always_ff @(posedge clk) begin
      if (reset) begin
         full      <= 1'b0;
         send_msg  <= '0;
         send_chan <= '0;
      end else if (xfer_in) begin
         full      <= 1'b1;
         send_msg  <= in_msg;
         send_chan <= g_idx;
      end else if (xfer_out) begin
         full      <= 1'b0;
      end
   end

   assign send_val = full;

endmodule

// File: tb/tb_arb_mux_n1.sv
// Directed bench for arb_mux_n1: an 8x32 instance and a 5x16 instance
// driven through reset, fixed-select, round-robin, backpressure and wrap.
module tb_arb_mux_n1;

   logic         clk;
   logic         reset8, reset5;
   logic [255:0] recv_msg8;
   logic [7:0]   recv_val8, recv_rdy8;
   logic         rr_en8;
   logic [2:0]   sel8;
   logic [31:0]  send_msg8;
   logic         send_val8, send_rdy8;
   logic [2:0]   send_chan8;

   logic [79:0]  recv_msg5;
   logic [4:0]   recv_val5, recv_rdy5;
   logic         rr_en5;
   logic [2:0]   sel5;
   logic [15:0]  send_msg5;
   logic         send_val5, send_rdy5;
   logic [2:0]   send_chan5;

   int compared   = 0;
   int mismatched = 0;
   logic [2:0] exp_q[$];
   logic [2:0] exp_chan;

   arb_mux_n1 #(.BIT_WIDTH(32), .N(8)) dut8 (
      .clk(clk), .reset(reset8), .recv_msg(recv_msg8), .recv_val(recv_val8),
      .recv_rdy(recv_rdy8), .rr_en(rr_en8), .sel(sel8), .send_msg(send_msg8),
      .send_val(send_val8), .send_rdy(send_rdy8), .send_chan(send_chan8)
   );

   arb_mux_n1 #(.BIT_WIDTH(16), .N(5)) dut5 (
      .clk(clk), .reset(reset5), .recv_msg(recv_msg5), .recv_val(recv_val5),
      .recv_rdy(recv_rdy5), .rr_en(rr_en5), .sel(sel5), .send_msg(send_msg5),
      .send_val(send_val5), .send_rdy(send_rdy5), .send_chan(send_chan5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   int rr_ord[6] = '{0, 2, 5, 7, 0, 2};
   int wr_ord[4] = '{4, 0, 4, 0};

   initial begin
      for (int i = 0; i < 8; i++) recv_msg8[i*32 +: 32] = 32'hDEAD0000 | 32'(i);
      for (int i = 0; i < 5; i++) recv_msg5[i*16 +: 16] = 16'hA000 | 16'(i);
      reset8 = 1'b1; reset5 = 1'b1;
      recv_val8 = 8'hFF; rr_en8 = 1'b1; sel8 = 3'd0; send_rdy8 = 1'b1;
      recv_val5 = 5'h00; rr_en5 = 1'b1; sel5 = 3'd0; send_rdy5 = 1'b1;

      // Reset held two cycles with every channel valid
      next_cyc();
      @(negedge clk);
      chk("rst_rdy", 64'(recv_rdy8), 64'(8'h00));
      chk("rst_val", 64'(send_val8), 64'(1'b0));
      chk("rst_msg", 64'(send_msg8), 64'(32'h0));
      chk("rst_chan", 64'(send_chan8), 64'(3'd0));
      next_cyc();
      reset8 = 1'b0; reset5 = 1'b0;
      recv_val8 = 8'b1010_0101;

      // RR fairness: grants 0,2,5,7,0,2 back-to-back, channel one cycle later
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rr_rdy", 64'(recv_rdy8), 64'(1 << rr_ord[k]));
         exp_q.push_back(3'(rr_ord[k]));
         next_cyc();
         exp_chan = exp_q.pop_front();
         chk("rr_chan", 64'(send_chan8), 64'(exp_chan));
         chk("rr_msg", 64'(send_msg8), 64'(32'hDEAD0000 | 32'(exp_chan)));
         chk("rr_val", 64'(send_val8), 64'(1'b1));
      end

      // Fixed-select mode; pointer is now 3
      rr_en8 = 1'b0; sel8 = 3'd3; recv_val8 = 8'hFF;
      @(negedge clk);
      chk("fix3_rdy", 64'(recv_rdy8), 64'(8'h08));
      next_cyc();
      chk("fix3_msg", 64'(send_msg8), 64'(32'hDEAD0003));
      chk("fix3_chan", 64'(send_chan8), 64'(3'd3));
      sel8 = 3'd7;
      @(negedge clk);
      chk("fix7_rdy", 64'(recv_rdy8), 64'(8'h80));
      next_cyc();
      chk("fix7_chan", 64'(send_chan8), 64'(3'd7));
      recv_val8 = 8'h7F;
      @(negedge clk);
      chk("fix_noval_rdy", 64'(recv_rdy8), 64'(8'h00));
      next_cyc();
      chk("drain_val", 64'(send_val8), 64'(1'b0));

      // Back to RR: fixed grants must not have moved the pointer from 3
      rr_en8 = 1'b1; recv_val8 = 8'hFF;
      @(negedge clk);
      chk("ptr_kept_rdy", 64'(recv_rdy8), 64'(8'h08));
      next_cyc();
      chk("ptr_kept_chan", 64'(send_chan8), 64'(3'd3));

      // Backpressure for three cycles, then drain and refill together
      send_rdy8 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_rdy", 64'(recv_rdy8), 64'(8'h00));
         next_cyc();
         chk("bp_msg", 64'(send_msg8), 64'(32'hDEAD0003));
         chk("bp_chan", 64'(send_chan8), 64'(3'd3));
         chk("bp_val", 64'(send_val8), 64'(1'b1));
      end
      send_rdy8 = 1'b1;
      @(negedge clk);
      chk("bp_release_rdy", 64'(recv_rdy8), 64'(8'h10));
      next_cyc();
      chk("bp_release_chan", 64'(send_chan8), 64'(3'd4));
      chk("bp_release_val", 64'(send_val8), 64'(1'b1));

      // Reset while a word is held and stalled
      send_rdy8 = 1'b0;
      next_cyc();
      chk("hold_chan", 64'(send_chan8), 64'(3'd4));
      reset8 = 1'b1; send_rdy8 = 1'b1;
      @(negedge clk);
      chk("midrst_rdy", 64'(recv_rdy8), 64'(8'h00));
      next_cyc();
      chk("midrst_val", 64'(send_val8), 64'(1'b0));
      chk("midrst_msg", 64'(send_msg8), 64'(32'h0));
      reset8 = 1'b0;
      @(negedge clk);
      chk("postrst_rdy", 64'(recv_rdy8), 64'(8'h01));
      next_cyc();
      chk("postrst_chan", 64'(send_chan8), 64'(3'd0));
      chk("postrst_msg", 64'(send_msg8), 64'(32'hDEAD0000));

      // Mode toggle is combinational; fixed grant leaves pointer at 1
      rr_en8 = 1'b0; sel8 = 3'd6;
      @(negedge clk);
      chk("toggle_fix_rdy", 64'(recv_rdy8), 64'(8'h40));
      next_cyc();
      chk("toggle_fix_chan", 64'(send_chan8), 64'(3'd6));
      rr_en8 = 1'b1;
      @(negedge clk);
      chk("toggle_rr_rdy", 64'(recv_rdy8), 64'(8'h02));
      next_cyc();

      // N=5: move pointer to 4 via channel 3, then alternate 4,0,4,0
      recv_val5 = 5'b01000;
      @(negedge clk);
      chk("n5_ch3_rdy", 64'(recv_rdy5), 64'(5'b01000));
      next_cyc();
      chk("n5_ch3_chan", 64'(send_chan5), 64'(3'd3));
      recv_val5 = 5'b10001;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("n5_wrap_rdy", 64'(recv_rdy5), 64'(1 << wr_ord[k]));
         exp_q.push_back(3'(wr_ord[k]));
         next_cyc();
         exp_chan = exp_q.pop_front();
         chk("n5_wrap_chan", 64'(send_chan5), 64'(exp_chan));
         chk("n5_wrap_msg", 64'(send_msg5), 64'(16'hA000 | 16'(exp_chan)));
      end

      // N=5 fixed mode: sel beyond N-1 grants nothing
      rr_en5 = 1'b0; sel5 = 3'd6; recv_val5 = 5'h1F;
      @(negedge clk);
      chk("n5_sel_oor_rdy", 64'(recv_rdy5), 64'(5'h00));
      next_cyc();
      chk("n5_sel_oor_val", 64'(send_val5), 64'(1'b0));
      sel5 = 3'd2;
      @(negedge clk);
      chk("n5_sel2_rdy", 64'(recv_rdy5), 64'(5'b00100));
      next_cyc();
      chk("n5_sel2_msg", 64'(send_msg5), 64'(16'hA002));
      chk("n5_sel2_chan", 64'(send_chan5), 64'(3'd2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/arb_mux_n1.md
Name: arb_mux_n1

Overview:
Parametrised, registered N:1 stream multiplexer with val/rdy handshakes on every input and on the output. It replaces the 8-way 32-bit combinational selector wherever sources are streams that may stall. It runs in one of two modes:
- Fixed-select: only the input chosen by `sel` is served.
- Round-robin: all valid inputs are arbitrated fairly.

It sits between multiple producer streams (e.g. FFT/filter lanes) and a single consumer.

Parameters:
- BIT_WIDTH, 32, payload width of every input and the output.
- N, 8, number of input channels (N >= 2).
- SEL_W, $clog2(N), select and grant-index width (derived; not overridden).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- recv_msg  input  N*BIT_WIDTH  packed input payloads; channel i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
- recv_val  input  N  per-channel valid.
- recv_rdy  output  N  per-channel ready; one-hot or zero.
- rr_en  input  1  1 = round-robin mode, 0 = fixed-select mode.
- sel  input  SEL_W  channel served in fixed-select mode; ignored when rr_en=1.
- send_msg  output  BIT_WIDTH  output payload (registered).
- send_val  output  1  output valid (registered).
- send_rdy  input  1  consumer ready.
- send_chan  output  SEL_W  index of the channel that produced the current send_msg (registered).

Behaviour:
- **Storage:** one output register holding send_msg, send_chan and a full flag; send_val = full.
- **Reset:** while reset=1 on a clock edge:
  - full=0, so send_val=0.
  - send_msg=0, send_chan=0.
  - RR priority pointer = 0.
  - recv_rdy=0 during reset cycles.
  - A reset mid-transfer discards the held word; no handshake completes in a reset cycle.
- **can_accept** = !full | send_rdy. This gives full throughput: one word per cycle when the consumer is always ready.
- **Fixed mode (rr_en=0):**
  - grant = one-hot(sel) if recv_val[sel], else 0.
  - sel values >= N grant nothing.
- **RR mode (rr_en=1):**
  - grant goes to the first valid channel scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - No valid channel means no grant.
- **Ready and transfer:**
  - recv_rdy = grant & {N{can_accept}}.
  - An input transfer occurs on channel g when recv_val[g] & recv_rdy[g].
  - At most one input transfer per cycle.
- **On an input transfer:**
  - send_msg <= recv_msg[g], send_chan <= g, full <= 1.
  - In RR mode, ptr <= (g+1) mod N. Wrap at N-1 goes to 0; non-power-of-2 N must wrap correctly.
- **Output without input:** an output transfer (send_val & send_rdy) with no simultaneous input transfer sets full <= 0.
- **Simultaneous output and input transfer:** the register is overwritten with the new word and full stays 1. There is no bubble.
- **Stall:** send_val=1 and send_rdy=0 means send_msg/send_chan hold stable and all recv_rdy=0.
- **Mode/select changes:**
  - ptr is updated only by RR-mode grants; fixed-mode grants leave ptr unchanged.
  - Toggling rr_en takes effect the same cycle (combinational).
  - A word already held is unaffected.
  - sel may change every cycle; it is sampled combinationally.
- **Timing:**
  - Latency is 1 cycle, input handshake to send_val.
  - recv_rdy depends combinationally on recv_val, sel, rr_en, send_rdy.
  - send_val/send_msg do not depend combinationally on any input.

Decomposition:
- Shared package arb_mux_pkg holds:
  - localparam helpers for SEL_W.
  - A function `rr_next(ptr, N)` giving the wrapped increment.
  - A function `onehot_to_idx`.
- Sub-module rr_arbiter_n:
  - Parameter N.
  - Ports clk, reset, en, req[N], grant[N], grant_idx.
  - Owns the priority pointer and performs the rotating priority scan.
  - Pointer advances on en & |grant.
- The top level instantiates rr_arbiter_n with en = rr_en & can_accept, and muxes between its grant and the fixed-select grant.

Test Plan:
- **Reset:** reset=1 for 2 cycles with all recv_val=1 -> send_val=0, recv_rdy=0; first cycle after release, RR grants channel 0.
- **Fixed mode:** rr_en=0, sel=3, recv_val=8'hFF, ch3 msg=32'hDEAD0003, send_rdy=1 -> recv_rdy=8'h08; next cycle send_msg=32'hDEAD0003, send_chan=3; changing sel=7 moves ready to 8'h80.
- **RR fairness:** rr_en=1, recv_val=8'b1010_0101 held, send_rdy=1 -> grant order 0,2,5,7,0,2,… one per cycle with no bubbles; send_chan follows 1 cycle later.
- **Backpressure:** RR, recv_val=8'hFF, send_rdy=0 for 3 cycles after first accept -> send_msg stable, recv_rdy=0, ptr frozen; on send_rdy=1, the next channel is accepted in the same cycle as the drain.
- **Wrap and odd N:** N=5, BIT_WIDTH=16, only ch4 and ch0 valid -> grants alternate 4,0,4,0; ptr wraps 4->0.
- **Reset mid-operation:** assert reset while send_val=1 and send_rdy=0 -> next cycle send_val=0; after release, the held word is never emitted and RR restarts at channel 0.
